mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-master-port controller that shares the single-port 128x32 word RAM between the instruction-fetch requester and the data (load/store) requester.
- Serialises accesses, sequences RAM control with write setup and a fixed access latency, and returns read data through per-port req/ack handshakes.
- Sits between the core's fetch/memory stages and the RAM; the top level builds the RAM tristate data bus from ram_wdata/ram_data_oe/ram_rdata.

Parameters:
- ADDR_W, 9, byte address width (512 B = 128 words).
- DATA_W, 32, data word width.
- ACCESS_CYCLES, 2, cycles the RAM is held per access; minimum 2 (write needs a setup cycle).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  DATA_W  fetched word, registered.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  misaligned access, pulses with d_ack.
- busy  out  1  high whenever state != IDLE.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wre  out  1  RAM control: 1 = read/drive, 0 = write.
- ram_flag  out  1  RAM instruction/data select; 1 during fetch grants.
- ram_wdata  out  DATA_W  write data toward the bus.
- ram_data_oe  out  1  arbiter drives the bus.
- ram_rdata  in  DATA_W  bus read value.

Behaviour:
- Reset values: if_rdata=0, d_rdata=0, acks=0, d_err=0, busy=0, ram_addr=0, ram_wre=1, ram_flag=0, ram_data_oe=0, ram_wdata=0.
- ram_wre is 1 in every cycle except write strobes. The RAM writes whenever wre is low, so it never idles low.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: sample the requests.
  - Simultaneous requests: d wins (default policy).
  - On grant, latch port id, address, we and wdata into registers; go to ACCESS with cnt=0.
  - Misaligned data grant (d_addr[1:0] != 0): skip ACCESS and go to RESP with an error.
  - Fetch address low bits are ignored, since the RAM indexes words.
- ACCESS: lasts ACCESS_CYCLES cycles (cnt 0..ACCESS_CYCLES-1).
  - ram_addr = latched address throughout; ram_flag = (grant == fetch).
  - Write: ram_data_oe=1 for all ACCESS cycles; ram_wre=0 only while cnt != 0, so cycle 0 is address/data setup.
  - Read: ram_wre=1, ram_data_oe=0; ram_rdata captured into the granted port's rdata register on the last ACCESS cycle.
- RESP: one cycle.
  - Granted port's ack=1; d_err=1 only on a misaligned data access.
  - ram_wre=1, ram_data_oe=0; return to IDLE.
- Latency: request seen in IDLE at cycle T -> ack at T+ACCESS_CYCLES+1 (T+1 for a misaligned access). Issue rate is one access per ACCESS_CYCLES+2 cycles.
- A request still high in the cycle after its ack is a new request (back-to-back allowed).
- A request dropped before ack: the access still completes and ack still pulses. A write dropped this way still writes.
- rdata registers hold their value until the next read on that port. A store or error leaves d_rdata unchanged.
- Reset mid-access: return to IDLE immediately. A write may be lost, but ram_wre returns to 1 in the reset cycle.
- Default policy permits fetch starvation under continuous d_req; this is documented behaviour.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register (reset = fetch) makes simultaneous requests go to the port not granted last; single requests are granted immediately.
- Undefined: fixed data-over-fetch priority and no last_grant register.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the port-id enum (PORT_IF, PORT_D);
  - the constant RAM_WORDS=128 and the alignment mask 2'b00.
- Sub-module mem_arb_timer: the loadable access down-counter producing first/last-cycle strobes.

Test Plan:
- Reset, then idle for 5 cycles -> ram_wre=1, ram_data_oe=0, busy=0, all acks 0.
- d store addr 0x010 data 0xDEADBEEF, then d load 0x010 -> ram_wre low exactly ACCESS_CYCLES-1 cycles; d_rdata=0xDEADBEEF; each ack at T+3.
- if_req and d_req asserted in the same cycle.
  - Default: d served first, fetch acked 4 cycles later.
  - With MEM_ARB_ROUND_ROBIN_EN and repeated simultaneous requests: grants alternate, fetch first.
- Fetch at 0x008 -> if_rdata equals RAM word 2 and ram_flag=1 during ACCESS.
- d load at 0x013 -> d_ack and d_err high at T+1, no RAM access, d_rdata unchanged.
- rst_n low during the write strobe cycle -> next cycle ram_wre=1, state IDLE, no ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM arbiter.
//   state_t    : arbiter FSM states (IDLE, ACCESS, RESP)
//   port_t     : requester identity (PORT_IF = fetch, PORT_D = data)
//   RAM_WORDS  : number of 32-bit words behind the arbiter
//   ALIGN_MASK : required value of a data byte address' low two bits
// Optional build macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  localparam int         RAM_WORDS  = 128;
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  // True when the byte offset addresses the start of a word.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester handshakes and the RAM side.
//   Fetch port : if_req, if_addr -> if_rdata, if_ack
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack, d_err
//   Status     : busy
//   RAM side   : ram_addr, ram_wre, ram_flag, ram_wdata, ram_data_oe, ram_rdata
// Modports: master = requesters plus RAM model, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wre;
  logic              ram_flag;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_data_oe;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, d_err, busy,
           ram_addr, ram_wre, ram_flag, ram_wdata, ram_data_oe
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, d_err, busy,
           ram_addr, ram_wre, ram_flag, ram_wdata, ram_data_oe
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter that times one RAM access.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : preset the counter to ACCESS_CYCLES-1 (issued on grant)
//   en         : high while the arbiter is in ACCESS
//   first      : high during the first access cycle (write setup)
//   last       : high during the final access cycle (read capture / exit)
module mem_arb_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic first,
  output logic last
);

  localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Remaining-cycle counter: preset on grant, counts down to zero in ACCESS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign first = en && (cnt_r == LOAD_VAL);
  assign last  = en && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between the fetch and data
// requesters. One access at a time: IDLE -> ACCESS (ACCESS_CYCLES) -> RESP.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : mem_arbiter_if.slave carrying both requester handshakes,
//                busy, and the RAM control/data signals
// Build option: MEM_ARB_ROUND_ROBIN_EN turns tie-breaking into alternation
// (last_grant register); without it the data port always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  state_t            state_r;
  state_t            next_state_s;
  port_t             port_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              if_ack_r;
  logic              d_ack_r;
  logic              d_err_r;

  logic              grant_valid_s;
  port_t             grant_port_s;
  logic              misaligned_s;
  logic              timer_load_s;
  logic              timer_en_s;
  logic              timer_first_s;
  logic              timer_last_s;
  logic              wr_strobe_s;
  logic              drive_s;
  logic              flag_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_t last_grant_r;

  // Remember the most recently granted port so a tie goes to the other one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= PORT_IF;
    end else if ((state_r == IDLE) && grant_valid_s) begin
      last_grant_r <= grant_port_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Arbitration between the two request lines (only acted on in IDLE).
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = PORT_D;
    if (bus.d_req && bus.if_req) begin
      grant_valid_s = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_port_s  = (last_grant_r == PORT_D) ? PORT_IF : PORT_D;
`else
      grant_port_s  = PORT_D;
`endif
    end else if (bus.d_req) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT_D;
    end else if (bus.if_req) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT_IF;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = PORT_D;
    end
    // Fetch low address bits are don't-care; only data accesses can fault.
    misaligned_s = (grant_port_s == PORT_D) && !is_aligned(bus.d_addr[1:0]);
  end

  mem_arb_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load_s),
    .en    (timer_en_s),
    .first (timer_first_s),
    .last  (timer_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and RAM control decode.
  always_comb begin
    next_state_s = state_r;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    wr_strobe_s  = 1'b0;
    drive_s      = 1'b0;
    flag_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          if (misaligned_s) begin
            next_state_s = RESP;
          end else begin
            next_state_s = ACCESS;
            timer_load_s = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        timer_en_s = 1'b1;
        flag_s     = (port_r == PORT_IF);
        drive_s    = we_r;
        // First access cycle is setup only; the strobe follows it.
        wr_strobe_s = we_r && !timer_first_s;
        if (timer_last_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = ACCESS;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Grant capture, read-data capture and response pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_r     <= PORT_IF;
      addr_r     <= {ADDR_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      d_err_r    <= 1'b0;
    end else begin
      if ((state_r == IDLE) && grant_valid_s) begin
        port_r <= grant_port_s;
        addr_r <= (grant_port_s == PORT_D) ? bus.d_addr : bus.if_addr;
        we_r   <= (grant_port_s == PORT_D) && bus.d_we;
        if ((grant_port_s == PORT_D) && bus.d_we) begin
          wdata_r <= bus.d_wdata;
        end else begin
          wdata_r <= wdata_r;
        end
      end else begin
        port_r  <= port_r;
        addr_r  <= addr_r;
        we_r    <= we_r;
        wdata_r <= wdata_r;
      end

      if ((state_r == ACCESS) && timer_last_s && !we_r) begin
        if (port_r == PORT_D) begin
          d_rdata_r <= bus.ram_rdata;
        end else begin
          if_rdata_r <= bus.ram_rdata;
        end
      end else begin
        d_rdata_r  <= d_rdata_r;
        if_rdata_r <= if_rdata_r;
      end

      // Entering RESP straight from IDLE only happens for a misaligned data
      // grant, so that path is an erroring data ack.
      if (next_state_s == RESP) begin
        if (state_r == IDLE) begin
          if_ack_r <= 1'b0;
          d_ack_r  <= 1'b1;
          d_err_r  <= 1'b1;
        end else begin
          if_ack_r <= (port_r == PORT_IF);
          d_ack_r  <= (port_r == PORT_D);
          d_err_r  <= 1'b0;
        end
      end else begin
        if_ack_r <= 1'b0;
        d_ack_r  <= 1'b0;
        d_err_r  <= 1'b0;
      end
    end
  end

  assign bus.if_rdata    = if_rdata_r;
  assign bus.d_rdata     = d_rdata_r;
  assign bus.if_ack      = if_ack_r;
  assign bus.d_ack       = d_ack_r;
  assign bus.d_err       = d_err_r;
  assign bus.busy        = (state_r != IDLE);
  assign bus.ram_addr    = addr_r;
  assign bus.ram_wdata   = wdata_r;
  assign bus.ram_flag    = flag_s;
  // Reset forces the RAM back to read/hi-Z in the very cycle it is asserted.
  assign bus.ram_wre     = ~(rst_n & wr_strobe_s);
  assign bus.ram_data_oe = rst_n & drive_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a RAM model and an
// ack-driven scoreboard (expected responses queued at issue time).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AC = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    wre_low_cnt = 0;
  int    oe_cnt = 0;
  int    flag_cnt = 0;
  exp_t  d_q[$];
  exp_t  if_q[$];
  logic [31:0] ram [RAM_WORDS];

  mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .ACCESS_CYCLES(AC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.ram_rdata = ram[bus.ram_addr[8:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // RAM model: word array written while the write-enable is low.
  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ram[i] = 32'hA500_0000 | i;
    forever begin
      @(negedge clk);
      if (bus.ram_wre === 1'b0) ram[bus.ram_addr[8:2]] = bus.ram_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and counts RAM activity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ram_wre === 1'b0) wre_low_cnt = wre_low_cnt + 1;
      if (bus.ram_data_oe === 1'b1) oe_cnt = oe_cnt + 1;
      if (bus.busy === 1'b1 && bus.ram_flag === 1'b1) flag_cnt = flag_cnt + 1;
      if (bus.d_ack === 1'b1) begin
        if (d_q.size() == 0) begin
          check("d_ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = d_q.pop_front();
          check("d_rdata", bus.d_rdata, e.data);
          check("d_err", {31'd0, bus.d_err}, {31'd0, e.err});
          check("d_ack_cycle", cyc, e.due);
        end
      end else if (bus.d_err !== 1'b0) begin
        check("d_err_without_ack", {31'd0, bus.d_err}, 32'd0);
      end
      if (bus.if_ack === 1'b1) begin
        if (if_q.size() == 0) begin
          check("if_ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = if_q.pop_front();
          check("if_rdata", bus.if_rdata, e.data);
          check("if_ack_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_start(input logic [8:0] a, input logic we, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input int lat);
    exp_t e;
    bus.d_req   = 1'b1;
    bus.d_addr  = a;
    bus.d_we    = we;
    bus.d_wdata = wd;
    e.data = ed;
    e.err  = ee;
    e.due  = cyc + lat;
    d_q.push_back(e);
  endtask

  task automatic if_start(input logic [8:0] a, input logic [31:0] ed, input int lat);
    exp_t e;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    e.data = ed;
    e.err  = 1'b0;
    e.due  = cyc + lat;
    if_q.push_back(e);
  endtask

  // Wait (bounded) for the data ack, then drop the request inside the ack cycle.
  task automatic d_wait();
    bit got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (bus.d_ack === 1'b1) got = 1'b1;
    end
    bus.d_req = 1'b0;
    if (!got) check("d_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic if_wait();
    bit got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (bus.if_ack === 1'b1) got = 1'b1;
    end
    bus.if_req = 1'b0;
    if (!got) check("if_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_counts();
    wre_low_cnt = 0;
    oe_cnt      = 0;
    flag_cnt    = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = 9'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 9'd0;
    bus.d_wdata = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ram_wre", {31'd0, bus.ram_wre}, 32'd1);
      check("idle_ram_oe", {31'd0, bus.ram_data_oe}, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    end
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_ram_addr", {23'd0, bus.ram_addr}, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_ram_flag", {31'd0, bus.ram_flag}, 32'd0);
    check("rst_d_err", {31'd0, bus.d_err}, 32'd0);

    // Store then load at 0x010.
    clear_counts();
    d_start(9'h010, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, AC + 1);
    d_wait();
    tick();
    check("store_wre_low_cycles", wre_low_cnt, AC - 1);
    check("store_oe_cycles", oe_cnt, AC);
    check("store_flag_cycles", flag_cnt, 32'd0);
    check("store_ram_word4", ram[4], 32'hDEAD_BEEF);
    clear_counts();
    d_start(9'h010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, AC + 1);
    d_wait();
    tick();
    check("load_wre_low_cycles", wre_low_cnt, 32'd0);

    // Fetch at 0x008 (word 2), then 0x00B (low bits ignored).
    clear_counts();
    if_start(9'h008, 32'hA500_0002, AC + 1);
    if_wait();
    tick();
    check("fetch_flag_cycles", flag_cnt, AC);
    if_start(9'h00B, 32'hA500_0002, AC + 1);
    if_wait();
    tick();

    // Simultaneous requests: data first, fetch one full slot later.
    d_start(9'h014, 1'b0, 32'h0, 32'hA500_0005, 1'b0, AC + 1);
    if_start(9'h00C, 32'hA500_0003, 2 * AC + 3);
    fork
      d_wait();
      if_wait();
    join
    tick();

    // Misaligned load and store: immediate error, no RAM activity.
    clear_counts();
    d_start(9'h013, 1'b0, 32'h0, 32'hA500_0005, 1'b1, 1);
    d_wait();
    tick();
    d_start(9'h012, 1'b1, 32'h1234_5678, 32'hA500_0005, 1'b1, 1);
    d_wait();
    tick();
    check("misaligned_wre_low", wre_low_cnt, 32'd0);
    check("misaligned_oe", oe_cnt, 32'd0);
    check("misaligned_word4", ram[4], 32'hDEAD_BEEF);

    // Store whose request is dropped right after the grant still completes.
    d_start(9'h020, 1'b1, 32'hCAFE_F00D, 32'hA500_0005, 1'b0, AC + 1);
    tick();
    bus.d_req = 1'b0;
    d_wait();
    tick();
    check("dropped_store_word8", ram[8], 32'hCAFE_F00D);
    d_start(9'h020, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, AC + 1);
    d_wait();
    tick();

    // Reset during the write strobe: no ack, no write, back to IDLE.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 9'h030;
    bus.d_wdata = 32'h1111_1111;
    tick();
    tick();
    check("strobe_before_reset", {31'd0, bus.ram_wre}, 32'd0);
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    #1;
    check("wre_in_reset_cycle", {31'd0, bus.ram_wre}, 32'd1);
    tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_ram_wre", {31'd0, bus.ram_wre}, 32'd1);
    check("reset_d_rdata", bus.d_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_word12_kept", ram[12], 32'hA500_000C);

    // Memory contents survive the reset.
    d_start(9'h010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, AC + 1);
    d_wait();
    tick();
    repeat (3) tick();

    check("d_queue_drained", d_q.size(), 32'd0);
    check("if_queue_drained", if_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
